// File: rtl/alu_multicycle.sv
// alu_multicycle: execute-stage ALU with a registered single-cycle path for
// or/and/add/sub and an iterative shift-add multiplier taking WIDTH cycles.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_i      synchronous active-high reset
//   valid_i    operation request present
//   ready_o    block can accept a request this cycle
//   ALUCtrl_i  000 or, 001 and, 010 add, 011 sub, 100 mul, 101-111 illegal
//   data1_i    operand A
//   data2_i    operand B
//   valid_o    one-cycle pulse marking a new result on data_o/zero_o/illegal_o
//   data_o     result, held until the next result
//   zero_o     registered (data_o == 0)
//   illegal_o  result came from an illegal code
//   stall_o    ~ready_o, for pipeline hazard logic
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic             stall_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    OP_OR  = 3'b000,
    OP_AND = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_MUL = 3'b100
  } alu_op_e;

  typedef enum logic {
    IDLE,
    MUL
  } state_e;

  state_e           state, state_next;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             accept;
  logic             last_step;

  assign accept    = valid_i && ready_o;
  assign last_step = (state == MUL) && (counter == CW'(WIDTH - 1));
  assign acc_next  = mplier[0] ? acc + mcand : acc;

  // Single-cycle operations; illegal codes yield zero.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUCtrl_i)
      OP_OR:   alu_res = data1_i | data2_i;
      OP_AND:  alu_res = data1_i & data2_i;
      OP_ADD:  alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (ALUCtrl_i == OP_MUL)) state_next = MUL;
      MUL:     if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready_o = (state == IDLE);
    stall_o = ~ready_o;
  end

  // Datapath and result registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter   <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      data_o    <= '0;
      zero_o    <= 1'b1;
      illegal_o <= 1'b0;
      valid_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (ALUCtrl_i == OP_MUL) begin
              counter <= '0;
              acc     <= '0;
              mcand   <= data1_i;
              mplier  <= data2_i;
            end else begin
              data_o    <= alu_res;
              zero_o    <= (alu_res == '0);
              illegal_o <= alu_ill;
              valid_o   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + CW'(1);
          // The final step's partial product is folded in directly so the
          // result lands on the same edge as the last iteration.
          if (last_step) begin
            data_o    <= acc_next;
            zero_o    <= (acc_next == '0);
            illegal_o <= 1'b0;
            valid_o   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
